uart_response_tx: RTL and testbench

- Downstream stage of the sensor connection block. Consumes its response pair (response_command, response_value) when the "data can be sent" level rises.
- Serialises the pair over the UART TX line as two 8N1 frames: command byte first, then value byte.
- Replaces ad-hoc byte sequencing at the top level. Gives a clean busy/done/overrun status for the continuous-sensing loop.

---
 rtl/uart_response_tx.sv | 174 +++++++++++++++++
 tb/tb_uart_response_tx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_response_tx.sv
// rtl/uart_response_tx.sv - sends a (command, value) response pair as two back-to-back 8N1 frames
// Optional one-entry pending buffer for requests that arrive while busy: define UART_RESP_PENDING_EN.
module uart_response_tx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       data_valid,
  input  logic [7:0] response_command,
  input  logic [7:0] response_value,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_n;
  logic [15:0] baud_cnt, baud_cnt_n;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic        byte_sel, byte_sel_n;
  logic [7:0]  cmd_q, cmd_n, val_q, val_n;
  logic        data_valid_q;
  logic        tx_n, busy_n, done_n, overrun_n;
  logic        request, baud_wrap;
  logic [7:0]  cur_byte;
`ifdef UART_RESP_PENDING_EN
  logic        pend_q, pend_n;
  logic [7:0]  pcmd_q, pcmd_n, pval_q, pval_n;
  logic        final_wrap;
`endif

  always_comb begin
    request    = data_valid & ~data_valid_q;
    baud_wrap  = (baud_cnt == BAUD_LAST);
    cur_byte   = byte_sel ? val_q : cmd_q;
    state_n    = state;
    baud_cnt_n = baud_wrap ? 16'd0 : baud_cnt + 16'd1;
    bit_cnt_n  = bit_cnt;
    byte_sel_n = byte_sel;
    cmd_n      = cmd_q;
    val_n      = val_q;
    tx_n       = tx;
    busy_n     = busy;
    done_n     = 1'b0;
    overrun_n  = 1'b0;
`ifdef UART_RESP_PENDING_EN
    pend_n     = pend_q;
    pcmd_n     = pcmd_q;
    pval_n     = pval_q;
    final_wrap = 1'b0;
`endif

    case (state)
      IDLE: begin
        baud_cnt_n = 16'd0;
        tx_n       = 1'b1;
        busy_n     = 1'b0;
        if (request) begin
          state_n    = START;
          cmd_n      = response_command;
          val_n      = response_value;
          byte_sel_n = 1'b0;
          bit_cnt_n  = 3'd0;
          tx_n       = 1'b0;
          busy_n     = 1'b1;
        end
      end
      START: begin
        if (baud_wrap) begin
          state_n   = DATA;
          bit_cnt_n = 3'd0;
          tx_n      = cur_byte[0];
        end
      end
      DATA: begin
        if (baud_wrap) begin
          if (bit_cnt == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
            tx_n      = cur_byte[bit_cnt_n];
          end
        end
      end
      STOP: begin
        if (baud_wrap) begin
          if (!byte_sel) begin
            // value frame starts straight after the command stop bit
            state_n    = START;
            byte_sel_n = 1'b1;
            tx_n       = 1'b0;
          end else begin
            state_n    = IDLE;
            byte_sel_n = 1'b0;
            tx_n       = 1'b1;
            busy_n     = 1'b0;
            done_n     = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

`ifdef UART_RESP_PENDING_EN
    if (state != IDLE && request) begin
      overrun_n = pend_q;
      pend_n    = 1'b1;
      pcmd_n    = response_command;
      pval_n    = response_value;
    end
    // a buffered pair (including one arriving this cycle) chains on without an IDLE cycle
    final_wrap = (state == STOP) && baud_wrap && byte_sel;
    if (final_wrap && pend_n) begin
      state_n    = START;
      byte_sel_n = 1'b0;
      bit_cnt_n  = 3'd0;
      cmd_n      = pcmd_n;
      val_n      = pval_n;
      pend_n     = 1'b0;
      tx_n       = 1'b0;
      busy_n     = 1'b1;
      done_n     = 1'b0;
    end
`else
    if (state != IDLE && request) begin
      overrun_n = 1'b1;
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      baud_cnt     <= 16'd0;
      bit_cnt      <= 3'd0;
      byte_sel     <= 1'b0;
      cmd_q        <= 8'd0;
      val_q        <= 8'd0;
      data_valid_q <= 1'b0;
      tx           <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      overrun      <= 1'b0;
`ifdef UART_RESP_PENDING_EN
      pend_q       <= 1'b0;
      pcmd_q       <= 8'd0;
      pval_q       <= 8'd0;
`endif
    end else begin
      state        <= state_n;
      baud_cnt     <= baud_cnt_n;
      bit_cnt      <= bit_cnt_n;
      byte_sel     <= byte_sel_n;
      cmd_q        <= cmd_n;
      val_q        <= val_n;
      data_valid_q <= data_valid;
      tx           <= tx_n;
      busy         <= busy_n;
      done         <= done_n;
      overrun      <= overrun_n;
`ifdef UART_RESP_PENDING_EN
      pend_q       <= pend_n;
      pcmd_q       <= pcmd_n;
      pval_q       <= pval_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_response_tx.sv
// tb/tb_uart_response_tx.sv - scoreboard bench for uart_response_tx at 16 clocks per bit
module tb_uart_response_tx;

  localparam int CPB = 16;

  logic       clock, reset, data_valid;
  logic [7:0] response_command, response_value;
  logic       tx, busy, done, overrun;

  uart_response_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clock(clock), .reset(reset), .data_valid(data_valid),
    .response_command(response_command), .response_value(response_value),
    .tx(tx), .busy(busy), .done(done), .overrun(overrun)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clock) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [7:0] exp_q[$];
  int start_q[$];
  int busy_cnt = 0, done_cnt = 0, ov_cnt = 0, last_done = 0;
  int extra = 0, tx_low_cnt = 0;

  always @(negedge clock) begin
    if (!reset) begin
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; last_done = cyc; end
      if (overrun) ov_cnt++;
      if (!tx) tx_low_cnt++;
    end
  end

  // UART receiver: samples each bit in its middle and pops the expected byte
  bit mon_act = 0;
  int mon_cnt = 0;
  logic [7:0] mon_sh;
  logic tx_prev = 1'b1;
  always @(negedge clock) begin
    if (reset) begin
      mon_act = 0;
    end else if (!mon_act) begin
      if (tx_prev && !tx) begin
        mon_act = 1;
        mon_cnt = 0;
        start_q.push_back(cyc);
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % CPB == CPB / 2) begin
        if (mon_cnt / CPB == 0) check("start_bit", tx, 0);
        else if (mon_cnt / CPB <= 8) mon_sh = {tx, mon_sh[7:1]};
        else begin
          check("stop_bit", tx, 1);
          if (exp_q.size() > 0) check("rx_byte", mon_sh, exp_q.pop_front());
          else extra++;
          mon_act = 0;
        end
      end
    end
    tx_prev = tx;
  end

  task automatic send(input logic [7:0] c, input logic [7:0] v, output int rc);
    data_valid = 1'b1;
    response_command = c;
    response_value = v;
    rc = cyc;
    exp_q.push_back(c);
    exp_q.push_back(v);
    @(negedge clock);
    response_command = 8'($urandom);
    response_value = 8'($urandom);
  endtask

  task automatic wait_done(input int limit, output bit found, output int dcyc);
    found = 0;
    dcyc = 0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clock);
      if (done) begin found = 1; dcyc = cyc; end
    end
  endtask

  int r, s0, d0, o0, dc, n;
  bit found;

  initial begin
    reset = 1'b1;
    data_valid = 1'b0;
    response_command = 8'h00;
    response_value = 8'h00;
    repeat (3) @(negedge clock);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    // single send
    busy_cnt = 0; s0 = start_q.size();
    send(8'h09, 8'h19, r);
    data_valid = 1'b0;
    wait_done(400, found, dc);
    check("single_done_seen", found, 1);
    check("single_done_cycle", dc - r, 321);
    check("single_busy_cycles", busy_cnt, 320);
    check("single_start_cycle", start_q[s0] - r, 1);
    repeat (20) @(negedge clock);

    // held level: one pair only
    s0 = start_q.size(); d0 = done_cnt;
    send(8'h0D, 8'h1A, r);
    repeat (2000) @(negedge clock);
    data_valid = 1'b0;
    check("held_starts", start_q.size() - s0, 2);
    check("held_dones", done_cnt - d0, 1);
    repeat (5) @(negedge clock);

    // second edge while busy
    s0 = start_q.size(); d0 = done_cnt; o0 = ov_cnt;
    send(8'h08, 8'h3C, r);
    data_valid = 1'b0;
    while (cyc < r + 100) @(negedge clock);
    data_valid = 1'b1;
    response_command = 8'hFF;
    response_value = 8'h0A;
`ifdef UART_RESP_PENDING_EN
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h0A);
`endif
    @(negedge clock);
    data_valid = 1'b0;
    repeat (700) @(negedge clock);
    check("busy_edge_dones", done_cnt - d0, 1);
`ifdef UART_RESP_PENDING_EN
    check("pend_overrun", ov_cnt - o0, 0);
    check("pend_starts", start_q.size() - s0, 4);
    check("pend_second_start", start_q[s0 + 2] - r, 321);
    check("pend_done_cycle", last_done - r, 641);
`else
    check("ovr_overrun", ov_cnt - o0, 1);
    check("ovr_starts", start_q.size() - s0, 2);
    check("ovr_done_cycle", last_done - r, 321);
`endif

    // reset mid-frame
    send(8'h55, 8'hAA, r);
    data_valid = 1'b0;
    while (cyc < r + 50) @(negedge clock);
    reset = 1'b1;
    #1;
    check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    exp_q.delete();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    s0 = start_q.size(); tx_low_cnt = 0;
    repeat (500) @(negedge clock);
    check("midrst_no_start", start_q.size() - s0, 0);
    check("midrst_tx_idle", tx_low_cnt, 0);

    // level held high across reset release counts as one edge
    data_valid = 1'b1;
    response_command = 8'h5A;
    response_value = 8'hC4;
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hC4);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    n = cyc; s0 = start_q.size();
    wait_done(400, found, dc);
    data_valid = 1'b0;
    check("relhigh_done_seen", found, 1);
    check("relhigh_start", start_q[s0] - n, 1);
    check("relhigh_done_cycle", dc - n, 321);
    repeat (10) @(negedge clock);

    // back-to-back: new edge in the done cycle
    send(8'h3C, 8'hC3, r);
    data_valid = 1'b0;
    wait_done(400, found, dc);
    check("b2b_first_done", found, 1);
    s0 = start_q.size();
    send(8'h07, 8'h07, r);
    data_valid = 1'b0;
    wait_done(400, found, dc);
    check("b2b_second_done", found, 1);
    check("b2b_start", start_q[s0] - r, 1);
    check("b2b_done_cycle", dc - r, 321);
    repeat (20) @(negedge clock);

    check("exp_q_empty", exp_q.size(), 0);
    check("extra_frames", extra, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
